branch_resolve: RTL and testbench

Branch resolution stage sitting directly downstream of the branch operand/target unit. Accepts rs1/rs2 operands, the precomputed branch target and the branch PC, evaluates the RV32I branch condition, and on a taken branch redirects fetch with a valid/ready handshake and flushes younger pipeline stages for a fixed number of cycles. Fetch runs static predict-not-taken, so only taken branches cause a redirect.

---
 rtl/rv_branch_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 35 +++
 rtl/branch_resolve.sv | 124 ++++++++++++
 tb/tb_branch_resolve.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_branch_pkg.sv
// Shared definitions for the branch resolution stage:
// funct3 codes, FSM states and flush counter width.
package rv_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } br_state_e;

endpackage

// File: rtl/branch_cmp.sv
// RV32I branch condition evaluator (purely combinational).
// Reserved funct3 codes 010/011 report illegal and never take.
module branch_cmp
    import rv_branch_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        taken_o,
    output logic        illegal_o
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1_i == rs2_i);
    assign lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu = (rs1_i < rs2_i);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = !eq;
            F3_BLT:  taken_o = lt;
            F3_BGE:  taken_o = !lt;
            F3_BLTU: taken_o = ltu;
            F3_BGEU: taken_o = !ltu;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: evaluates the branch, redirects fetch on a
// taken aligned branch and flushes younger stages afterwards.
module branch_resolve
    import rv_branch_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1data,
    input  logic [31:0] rs2data,
    input  logic [31:0] pcvalue,
    input  logic [31:0] br_pc,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);

    br_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      redirect_pc_q;
    logic [31:0]      br_pc_q;
    logic             misalign_q;
    logic             illegal_q;
    logic [31:0]      branch_cnt_q;
    logic [31:0]      taken_cnt_q;

    logic cmp_taken;
    logic cmp_illegal;
    logic accept;
    logic aligned;
    logic go_redirect;
    logic unused_br_pc;

    branch_cmp u_cmp (
        .funct3_i  (funct3),
        .rs1_i     (rs1data),
        .rs2_i     (rs2data),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    assign accept      = br_valid && br_ready;
    assign aligned     = (pcvalue[1:0] == 2'b00);
    assign go_redirect = accept && cmp_taken && aligned;
    // Branch PC is captured for debug visibility only.
    assign unused_br_pc = ^br_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (go_redirect) state_d = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        br_ready       = (state_q == IDLE);
        redirect_valid = (state_q == REDIRECT);
        flush          = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc_q <= '0;
            br_pc_q       <= '0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else begin
            misalign_q <= accept && cmp_taken && !aligned;
            illegal_q  <= accept && cmp_illegal;
            if (accept) begin
                br_pc_q      <= br_pc;
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (go_redirect) begin
                redirect_pc_q <= pcvalue;
                taken_cnt_q   <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_pc = redirect_pc_q;
    assign misalign    = misalign_q;
    assign illegal     = illegal_q;
    assign branch_cnt  = branch_cnt_q;
    assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed cases then
// randomized branches against a behavioural reference model.
module tb_branch_resolve;

    localparam int FD = 2;
    localparam int K_RED = 0;
    localparam int K_MIS = 1;
    localparam int K_ILL = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1data = '0;
    logic [31:0] rs2data = '0;
    logic [31:0] pcvalue = '0;
    logic [31:0] br_pc = '0;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        misalign;
    logic        illegal;
    logic [31:0] branch_cnt;
    logic [31:0] taken_cnt;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    int unsigned mb = 0;
    int unsigned mt = 0;
    bit rr_force = 1'b1;
    bit rr_val = 1'b1;

    branch_resolve #(.FLUSH_DEPTH(FD)) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .funct3         (funct3),
        .rs1data        (rs1data),
        .rs2data        (rs2data),
        .pcvalue        (pcvalue),
        .br_pc          (br_pc),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .misalign       (misalign),
        .illegal        (illegal),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_accept(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] pc);
        exp_t e;
        mb++;
        e.pc = pc;
        if (f == 3'd2 || f == 3'd3) begin
            e.kind = K_ILL;
            q.push_back(e);
        end else if (ref_taken(f, a, b)) begin
            if (pc[1:0] != 2'b00) begin
                e.kind = K_MIS;
            end else begin
                e.kind = K_RED;
                mt++;
            end
            q.push_back(e);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after accept.
    task automatic send(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc);
        br_valid = 1'b1;
        funct3   = f;
        rs1data  = a;
        rs2data  = b;
        pcvalue  = pc;
        br_pc    = $urandom;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (br_ready) begin
                model_accept(f, a, b, pc);
                @(posedge clk);
                #1;
                br_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        br_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            if (br_ready && q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            redirect_ready = rr_force ? rr_val : ($urandom_range(2) != 0);
        end
    end

    // Monitor: pops expected events as the DUT presents them.
    initial begin
        int fl;
        int rv;
        exp_t e;
        fl = 0;
        rv = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fl = 0;
                rv = 0;
            end else begin
                chk("ready_vs_flush", br_ready, !flush);
                if (misalign || illegal) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("pulse_kind", misalign ? K_MIS : K_ILL, e.kind);
                        chk("pulse_no_redirect", redirect_valid, 1'b0);
                        chk("pulse_no_flush", flush, 1'b0);
                    end
                end
                if (redirect_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_redirect", 32'd1, 32'd0);
                    end else begin
                        chk("redirect_kind", q[0].kind, K_RED);
                        chk("redirect_pc", redirect_pc, q[0].pc);
                        if (redirect_ready) void'(q.pop_front());
                    end
                end
                if (flush) begin
                    fl++;
                    if (redirect_valid) rv++;
                end else if (fl != 0) begin
                    chk("flush_len", fl, rv + FD);
                    fl = 0;
                    rv = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] c0;
        time t0;
        logic [2:0] f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_br_ready", br_ready, 1'b1);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_branch_cnt", branch_cnt, 32'h0);
        chk("rst_taken_cnt", taken_cnt, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(3'd0, 32'h5, 32'h5, 32'h100);
        chk("beq_rv", redirect_valid, 1'b1);
        chk("beq_pc", redirect_pc, 32'h100);
        chk("beq_taken_cnt", taken_cnt, 32'd1);
        wait_idle();

        send(3'd4, 32'hFFFF_FFFF, 32'h1, 32'h180);
        chk("blt_taken", redirect_valid, 1'b1);
        wait_idle();
        send(3'd6, 32'hFFFF_FFFF, 32'h1, 32'h1C0);
        chk("bltu_ready", br_ready, 1'b1);
        chk("bltu_rv", redirect_valid, 1'b0);

        rr_val = 1'b0;
        send(3'd1, 32'h3, 32'h4, 32'h240);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rv", redirect_valid, 1'b1);
            chk("stall_pc", redirect_pc, 32'h240);
            chk("stall_flush", flush, 1'b1);
            chk("stall_ready", br_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        rr_val = 1'b1;
        wait_idle();

        c0 = taken_cnt;
        send(3'd5, 32'h9, 32'h2, 32'h102);
        chk("mis_pulse", misalign, 1'b1);
        chk("mis_rv", redirect_valid, 1'b0);
        chk("mis_flush", flush, 1'b0);
        chk("mis_taken_cnt", taken_cnt, c0);
        @(posedge clk);
        #1;
        chk("mis_one_cycle", misalign, 1'b0);

        send(3'd2, 32'h1, 32'h1, 32'h300);
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_rv", redirect_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("ill_one_cycle", illegal, 1'b0);

        wait_idle();
        c0 = branch_cnt;
        t0 = $time;
        for (int i = 0; i < 4; i++) send(3'd0, i, i + 1, 32'h400);
        chk("b2b_cnt", branch_cnt, c0 + 32'd4);
        chk("b2b_cycles", 32'(($time - t0) / 10), 32'd4);

        rr_force = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            f = 3'($urandom_range(7));
            a = $urandom;
            case ($urandom_range(3))
                0: b = a;
                1: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(5) == 0) pc[1:0] = 2'($urandom_range(3));
            send(f, a, b, pc);
        end
        rr_force = 1'b1;
        rr_val = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("rand_branch_cnt", branch_cnt, mb);
        chk("rand_taken_cnt", taken_cnt, mt);
        @(posedge clk);
        #1;

        send(3'd0, 32'h7, 32'h7, 32'h500);
        @(posedge clk);
        #3;
        chk("pre_rst_flush", flush, 1'b1);
        rst = 1'b1;
        q.delete();
        mb = 0;
        mt = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_flush", flush, 1'b0);
        chk("mid_rst_ready", br_ready, 1'b1);
        chk("mid_rst_rv", redirect_valid, 1'b0);
        chk("mid_rst_bcnt", branch_cnt, 32'h0);
        chk("mid_rst_tcnt", taken_cnt, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(3'd1, 32'h1, 32'h2, 32'h600);
        wait_idle();
        chk("post_rst_bcnt", branch_cnt, mb);
        chk("post_rst_tcnt", taken_cnt, mt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
